stc_pingpong_abuffer: RTL
=========================

Name: stc_pingpong_Abuffer

Overview:
Double-buffered sparse-A operand buffer for the sparse tensor core, and the parametrised successor of the single-bank A buffer. Each bank holds M rows of K (value, column-index) pairs. A loader fills one bank row by row while the datapath gathers NP entries per cycle from the other bank through flat pointers. Bank ownership passes between loader and datapath through commit/release handshakes.

Parameters:
M, 16, rows per bank (power of two)
K, 16, entries per row (power of two)
DW_DATA, 16, value width
DW_COL, 4, column-index width
DW_PTR, 8, flat pointer width; must be >= log2(M*K)
NP, 4, gather lanes per cycle

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
wr_data_en  in  1  write wr_data into row wr_row of the write bank
wr_cidx_en  in  1  write wr_cidx into row wr_row of the write bank
wr_row  in  log2(M)  target row
wr_data  in  K*DW_DATA  row values; entry j at [j*DW_DATA +: DW_DATA]
wr_cidx  in  K*DW_COL  row column indices; entry j at [j*DW_COL +: DW_COL]
wr_commit  in  1  write bank complete; hand it to the reader
wr_ready  out  1  write bank is free; writes and commit are accepted
rd_req  in  1  gather request
rd_ptrs  in  NP*DW_PTR  flat pointers; lane i at [i*DW_PTR +: DW_PTR], row = ptr/K, col = ptr%K
rd_mask  in  NP  lane enables
rd_release  in  1  read bank consumed; return it to the writer
rd_ready  out  1  a committed bank is available for reading
out_valid  out  1  gather result valid
out_data  out  NP*DW_DATA  gathered values
out_cols  out  NP*DW_COL  gathered column indices
out_err  out  NP  per-lane pointer out of range (ptr >= M*K)

Behaviour:
- Banks: two banks (0 and 1). Per-bank full flag. wr_bank and rd_bank select registers.
- Handshake outputs: wr_ready = !full[wr_bank]; rd_ready = full[rd_bank]. Both are combinational from registers.
- Reset (reset = 0, asynchronous):
  - full = 00, wr_bank = 0, rd_bank = 0.
  - out_valid = 0; out_data, out_cols, out_err all 0.
  - Storage arrays are not reset.
- Writes:
  - Applied at the clock edge only when wr_ready = 1; otherwise silently dropped.
  - data and cidx enables are independent. Both asserted on the same row updates both arrays.
  - Rewriting a row overwrites it.
- Commit: wr_commit with wr_ready = 1 sets full[wr_bank] and toggles wr_bank. Commit with wr_ready = 0 is ignored.
- Write plus commit in the same cycle: the write lands in the bank being committed.
- Gather:
  - Accepted when rd_req = 1 and rd_ready = 1.
  - Next cycle: out_valid = 1, and each lane with rd_mask[i] = 1 and an in-range pointer gets data/cidx from rd_bank.
  - Masked lanes output 0 with out_err[i] = 0.
  - Out-of-range lanes output 0 with out_err[i] = 1.
- Gather rejected (rd_req with rd_ready = 0): out_valid = 0 next cycle and outputs hold their previous values. Outputs also hold whenever out_valid = 0.
- Latency: one cycle, fully pipelined, one gather per cycle.
- Duplicate pointers across lanes are legal; each lane reads independently.
- Release: rd_release with rd_ready = 1 clears full[rd_bank] and toggles rd_bank. Release with rd_ready = 0 is ignored.
- Gather plus release in the same cycle: the gather reads the bank being released; the result is still valid next cycle.
- Commit and release in the same cycle: legal. They always target different banks, because commit needs a free bank and release needs a full one.
- Both banks full: wr_ready = 0 until a release.
- Both banks empty: rd_ready = 0.
- Bank order: banks strictly alternate, so reads occur in commit order.
- Reset mid-operation: all handshake state and outputs clear immediately. Any in-flight gather result is discarded.

Decomposition:
- Shared package stc_pkg holds: the widths DW_DATA, DW_COL, DW_PTR; function clog2; localparams ROW_W = clog2(M) and COL_W = clog2(K).
- One natural sub-module: stc_Abuf_bank, a single M×K storage bank with a row-write port and NP combinational gather ports. It is instantiated twice.
- Top level holds: full flags, bank selects, the output mux, error detection and output registers.

Test Plan:
- Reset, then fill bank 0 with data = 16*r+j and cidx = j for r = 0..15; commit. Then gather ptrs {3, 17, 255, 0}. Expect next cycle: out_valid = 1, data {3, 17, 255, 0}, cols {3, 1, 15, 0}, wr_ready = 1, rd_ready = 1.
- Fill and commit both banks without a release. Then attempt a third-row write of 0xFFFF. Expect wr_ready = 0, write dropped; after release, bank 0 reads its old values (no 0xFFFF).
- rd_mask = 4'b0101 with ptrs {5, 6, 7, 8}. Expect lanes 1 and 3 = 0, lanes 0 and 2 = values at entries 8 and 6; out_err = 0.
- With M = 8, ptr 200: out_err for that lane = 1, data = 0; other lanes unaffected.
- Same cycle: gather on bank 0, release of bank 0, commit of bank 1. Expect gather returns bank 0 data; next cycle rd_bank = 1, full = 2'b10, wr_bank = 0.
- Assert reset low mid-gather. Expect out_valid drops to 0 asynchronously, both ready flags show the empty state (wr_ready = 1, rd_ready = 0), and a later gather is rejected until the next commit.

Source files
------------

// File: rtl/stc_pkg.sv
// Shared widths and helpers for the sparse tensor core operand buffers.
package stc_pkg;

  localparam int DW_DATA = 16;
  localparam int DW_COL  = 4;
  localparam int DW_PTR  = 8;
  localparam int M_DEF   = 16;
  localparam int K_DEF   = 16;
  localparam int NP_DEF  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int ROW_W = clog2(M_DEF);
  localparam int COL_W = clog2(K_DEF);

endpackage

// File: rtl/stc_abuf_bank.sv
// One M x K bank of (value, column-index) pairs: row-wide write port,
// NP combinational gather ports. Storage is intentionally not reset.
module stc_abuf_bank
  import stc_pkg::*;
#(
  parameter int M        = M_DEF,
  parameter int K        = K_DEF,
  parameter int NP       = NP_DEF,
  parameter int DAT_W    = DW_DATA,
  parameter int CID_W    = DW_COL,
  parameter int ROW_BITS = clog2(M),
  parameter int COL_BITS = clog2(K)
) (
  input  logic                         clk,
  input  logic                         wr_data_en,
  input  logic                         wr_cidx_en,
  input  logic [ROW_BITS-1:0]          wr_row,
  input  logic [K-1:0][DAT_W-1:0]      wr_data,
  input  logic [K-1:0][CID_W-1:0]      wr_cidx,
  input  logic [NP-1:0][ROW_BITS-1:0]  rd_row,
  input  logic [NP-1:0][COL_BITS-1:0]  rd_col,
  output logic [NP-1:0][DAT_W-1:0]     rd_data,
  output logic [NP-1:0][CID_W-1:0]     rd_cidx
);

  logic [K-1:0][DAT_W-1:0] data_mem [M];
  logic [K-1:0][CID_W-1:0] cidx_mem [M];

  always_ff @(posedge clk) begin
    if (wr_data_en) data_mem[wr_row] <= wr_data;
    if (wr_cidx_en) cidx_mem[wr_row] <= wr_cidx;
  end

  for (genvar i = 0; i < NP; i++) begin : g_rd
    assign rd_data[i] = data_mem[rd_row[i]][rd_col[i]];
    assign rd_cidx[i] = cidx_mem[rd_row[i]][rd_col[i]];
  end

endmodule

// File: rtl/stc_pingpong_abuffer.sv
// Double-buffered sparse-A operand buffer: loader fills one bank while the
// datapath gathers NP entries per cycle from the other; ownership via commit/release.
module stc_pingpong_abuffer #(
  parameter int M       = 16,
  parameter int K       = 16,
  parameter int DW_DATA = stc_pkg::DW_DATA,
  parameter int DW_COL  = stc_pkg::DW_COL,
  parameter int DW_PTR  = stc_pkg::DW_PTR,
  parameter int NP      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_data_en,
  input  logic                          wr_cidx_en,
  input  logic [stc_pkg::clog2(M)-1:0]  wr_row,
  input  logic [K*DW_DATA-1:0]          wr_data,
  input  logic [K*DW_COL-1:0]           wr_cidx,
  input  logic                          wr_commit,
  output logic                          wr_ready,
  input  logic                          rd_req,
  input  logic [NP*DW_PTR-1:0]          rd_ptrs,
  input  logic [NP-1:0]                 rd_mask,
  input  logic                          rd_release,
  output logic                          rd_ready,
  output logic                          out_valid,
  output logic [NP*DW_DATA-1:0]         out_data,
  output logic [NP*DW_COL-1:0]          out_cols,
  output logic [NP-1:0]                 out_err
);

  import stc_pkg::*;

  localparam int ROW_BITS = clog2(M);
  localparam int COL_BITS = clog2(K);
  localparam logic [DW_PTR:0] N_ENT = (DW_PTR+1)'(M*K);

  logic [1:0] full, full_nxt;
  logic       wr_bank, rd_bank;
  logic [1:0] wr_sel;
  logic       gather_go, commit_go, release_go;

  logic [NP-1:0][ROW_BITS-1:0] lane_row;
  logic [NP-1:0][COL_BITS-1:0] lane_col;
  logic [NP-1:0]               lane_oor, lane_hit;
  logic [NP-1:0][DW_DATA-1:0]  nxt_data, data_q;
  logic [NP-1:0][DW_COL-1:0]   nxt_cols, cols_q;
  logic [NP-1:0]               nxt_err,  err_q;

  logic [NP-1:0][DW_DATA-1:0]  bk_data [2];
  logic [NP-1:0][DW_COL-1:0]   bk_cidx [2];

  assign wr_ready   = ~full[wr_bank];
  assign rd_ready   = full[rd_bank];
  assign gather_go  = rd_req & rd_ready;
  assign commit_go  = wr_commit & wr_ready;
  assign release_go = rd_release & rd_ready;
  assign wr_sel     = wr_ready ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;

  // Commit and release can never hit the same bank (free vs full), so both
  // updates apply independently in one cycle.
  always_comb begin
    full_nxt = full;
    if (commit_go)  full_nxt[wr_bank] = 1'b1;
    if (release_go) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= full_nxt;
      if (commit_go)  wr_bank <= ~wr_bank;
      if (release_go) rd_bank <= ~rd_bank;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    stc_abuf_bank #(
      .M(M), .K(K), .NP(NP), .DAT_W(DW_DATA), .CID_W(DW_COL)
    ) u_bank (
      .clk        (clk),
      .wr_data_en (wr_data_en & wr_sel[b]),
      .wr_cidx_en (wr_cidx_en & wr_sel[b]),
      .wr_row     (wr_row),
      .wr_data    (wr_data),
      .wr_cidx    (wr_cidx),
      .rd_row     (lane_row),
      .rd_col     (lane_col),
      .rd_data    (bk_data[b]),
      .rd_cidx    (bk_cidx[b])
    );
  end

  // Flat pointer splits as row = ptr / K, col = ptr % K; anything past the
  // last entry is flagged instead of wrapping into the bank.
  for (genvar i = 0; i < NP; i++) begin : g_lane
    logic [DW_PTR-1:0] ptr;
    assign ptr         = rd_ptrs[i*DW_PTR +: DW_PTR];
    assign lane_row[i] = ptr[COL_BITS +: ROW_BITS];
    assign lane_col[i] = ptr[COL_BITS-1:0];
    assign lane_oor[i] = ({1'b0, ptr} >= N_ENT);
    assign lane_hit[i] = rd_mask[i] & ~lane_oor[i];
    assign nxt_data[i] = lane_hit[i] ? bk_data[rd_bank][i] : '0;
    assign nxt_cols[i] = lane_hit[i] ? bk_cidx[rd_bank][i] : '0;
    assign nxt_err[i]  = rd_mask[i] & lane_oor[i];
  end

  // Results hold between accepted gathers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      data_q    <= '0;
      cols_q    <= '0;
      err_q     <= '0;
    end else begin
      out_valid <= gather_go;
      if (gather_go) begin
        data_q <= nxt_data;
        cols_q <= nxt_cols;
        err_q  <= nxt_err;
      end
    end
  end

  assign out_data = data_q;
  assign out_cols = cols_q;
  assign out_err  = err_q;

endmodule
